// File: rtl/bp_fe_bp_update_queue.sv
// Program-ordered queue of issued branch predictions feeding the BHT write port.
// Pops in order on resolve and emits a registered {w_v, idx, correct} update.
module bp_fe_bp_update_queue #(
  parameter int bht_idx_width_p = 8,
  parameter int depth_p         = 8,
  localparam int ptr_width_lp   = $clog2(depth_p),
  localparam int cnt_width_lp   = $clog2(depth_p+1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic                       mispredict_o,
  output logic [cnt_width_lp-1:0]    count_o,
  output logic                       underflow_o
);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       taken;
  } entry_s;

  localparam logic [cnt_width_lp-1:0] depth_c = cnt_width_lp'(depth_p);

  entry_s [depth_p-1:0]    mem;
  logic [ptr_width_lp-1:0] wr_ptr, rd_ptr;
  logic [cnt_width_lp-1:0] count;
  entry_s                  head;
  logic full, empty, deq, enq, mispredict_now, squash;

  assign full           = (count == depth_c);
  assign empty          = (count == '0);
  assign head           = mem[rd_ptr];
  assign deq            = res_v_i & ~empty;
  assign mispredict_now = deq & (head.taken != res_taken_i);
  assign squash         = flush_i | mispredict_now;
  // A squash cycle drops the same-cycle prediction: it belongs to the wrong path.
  assign enq            = pred_v_i & ~full & ~squash;

  assign pred_ready_o = ~full;
  assign count_o      = count;

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= '{idx: pred_idx_i, taken: pred_taken_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      w_v_o        <= 1'b0;
      idx_w_o      <= '0;
      correct_o    <= 1'b0;
      mispredict_o <= 1'b0;
      underflow_o  <= 1'b0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + ptr_width_lp'(1);
      if (squash) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (deq) rd_ptr <= rd_ptr + ptr_width_lp'(1);
        count <= count + cnt_width_lp'(enq) - cnt_width_lp'(deq);
      end
      w_v_o        <= deq;
      mispredict_o <= mispredict_now;
      if (deq) begin
        idx_w_o   <= head.idx;
        correct_o <= ~mispredict_now;
      end
      if (res_v_i & empty) underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Directed test-plan scenarios plus random traffic, checked every cycle
// against a queue-based reference model.
module tb_bp_fe_bp_update_queue;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         pred_v_i = 1'b0, pred_taken_i = 1'b0;
  logic [W-1:0] pred_idx_i = '0;
  logic         res_v_i = 1'b0, res_taken_i = 1'b0, flush_i = 1'b0;
  logic         pred_ready_o, w_v_o, correct_o, mispredict_o, underflow_o;
  logic [W-1:0] idx_w_o;
  logic [3:0]   count_o;

  bp_fe_bp_update_queue #(.bht_idx_width_p(W), .depth_p(D)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
    .pred_ready_o(pred_ready_o),
    .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i),
    .w_v_o(w_v_o), .idx_w_o(idx_w_o), .correct_o(correct_o),
    .mispredict_o(mispredict_o), .count_o(count_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: outstanding predictions in program order, {idx, taken}.
  logic [W:0]   q[$];
  logic         e_wv = 0, e_cor = 0, e_mis = 0, e_uf = 0;
  logic [W-1:0] e_idx = '0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count_o), q.size());
    chk("ready", 32'(pred_ready_o), 32'(q.size() < D));
    chk("w_v", 32'(w_v_o), 32'(e_wv));
    chk("idx_w", 32'(idx_w_o), 32'(e_idx));
    chk("correct", 32'(correct_o), 32'(e_cor));
    chk("mispredict", 32'(mispredict_o), 32'(e_mis));
    chk("underflow", 32'(underflow_o), 32'(e_uf));
    if (count_o > 4'(D)) chk("count_bound", 32'(count_o), D);
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(bit pv, int pidx, bit pt, bit rv, bit rt, bit fl);
    int sz;
    bit deq, mis;
    logic [W:0] h;
    logic [W-1:0] pi;
    pi = pidx[W-1:0];
    pred_v_i = pv; pred_idx_i = pi; pred_taken_i = pt;
    res_v_i = rv; res_taken_i = rt; flush_i = fl;
    sz  = q.size();
    deq = rv && sz > 0;
    mis = 0;
    e_wv = deq;
    if (deq) begin
      h = q.pop_front();
      mis = (h[0] != rt);
      e_idx = h[W:1];
      e_cor = !mis;
    end
    e_mis = mis;
    if (rv && sz == 0) e_uf = 1;
    if (fl || mis) q.delete();
    else if (pv && sz < D) q.push_back({pi, pt});
    @(posedge clk); #1;
    pred_v_i = 0; res_v_i = 0; flush_i = 0;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2 reset_n_i = 0;
    #1;
    q.delete();
    e_wv = 0; e_cor = 0; e_mis = 0; e_uf = 0; e_idx = '0;
    check_all();
    @(posedge clk); #1;
    reset_n_i = 1;
    idle();
  endtask

  task automatic drain();
    while (q.size() > 0) step(0, 0, 0, 1, q[0][0], 0);
    idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset_n_i = 1;
    idle();

    // Reset mid-run with 5 entries: nothing may be emitted for them.
    for (int i = 0; i < 5; i++) step(1, 40 + i, i[0], 0, 0, 0);
    do_reset();
    idle();

    // 3/T, 7/N, 12/T resolved T, N, N: third one mispredicts.
    step(1, 3, 1, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0);
    step(1, 12, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle();
    chk("mis_third", 32'(count_o), 0);

    // Fill, overfill, then resolve+enqueue across pointer wrap.
    for (int i = 0; i < 8; i++) step(1, 20 + i, i[0], 0, 0, 0);
    step(1, 99, 1, 0, 0, 0);
    chk("full_ready", 32'(pred_ready_o), 0);
    for (int i = 0; i < 10; i++) step(1, 60 + i, i[1], 1, q[0][0], 0);
    drain();

    // Mispredict on the head with a simultaneous prediction.
    for (int i = 0; i < 4; i++) step(1, 80 + i, 1, 0, 0, 0);
    step(1, 99, 1, 1, ~q[0][0], 0);
    idle();

    // Flush with a same-cycle resolve, then resolve on empty.
    step(1, 5, 1, 0, 0, 0);
    step(1, 6, 0, 0, 0, 0);
    step(1, 9, 1, 0, 0, 0);
    step(1, 77, 0, 1, 1, 1);
    idle();
    step(0, 0, 0, 1, 0, 0);
    idle();
    chk("uf_sticky", 32'(underflow_o), 1);

    // Back-to-back resolves on a queue of 6.
    for (int i = 0; i < 6; i++) step(1, 100 + i, i[0], 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, q[0][0], 0);
    idle();

    do_reset();

    // Random traffic; resolves usually match the head to keep the queue busy.
    for (int i = 0; i < 3000; i++) begin
      bit rv, rt;
      rv = ($urandom_range(99) < ((i / 500) % 2 ? 30 : 55));
      rt = (q.size() > 0 && $urandom_range(9) < 8) ? q[0][0] : 1'($urandom);
      step($urandom_range(99) < 65, $urandom_range(255), 1'($urandom),
           rv, rt, $urandom_range(99) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
